// File: rtl/vga_plot_pkg.sv
// Shared encodings and default dimensions for the VGA plot arbiter and its raster counter.
package vga_plot_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int DIM_W_DEF    = 8;
  localparam int COL_W_DEF    = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/vga_plot_rect_raster.sv
// Column/row counters walking a w x h rectangle one pixel per clock; cx/cy index the pixel on the output.
module rect_raster
  import vga_plot_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_w,
  input  logic [DIM_W-1:0] i_h,
  output logic [DIM_W-1:0] o_cx,
  output logic [DIM_W-1:0] o_cy,
  output logic             o_active,
  output logic             o_row_end,
  output logic             o_last
);

  logic [DIM_W-1:0] r_cx;
  logic [DIM_W-1:0] r_cy;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic             r_active;

  assign o_cx      = r_cx;
  assign o_cy      = r_cy;
  assign o_active  = r_active;
  assign o_row_end = r_active && (r_cx == r_w - 1'b1);
  assign o_last    = o_row_end && (r_cy == r_h - 1'b1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_w      <= i_w;
      r_h      <= i_h;
      r_cx     <= '0;
      r_cy     <= '0;
      // An empty rectangle never becomes active, so it produces no pixels.
      r_active <= (i_w != '0) && (i_h != '0);
    end else if (r_active) begin
      if (o_last) begin
        r_active <= 1'b0;
        r_cx     <= '0;
        r_cy     <= '0;
      end else if (o_row_end) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter rasterising client fill-rectangle commands onto the vga_adapter plot port.
// Optional VGA_PLOT_CLIP_EN suppresses vga_plot for pixels outside SCREEN_W x SCREEN_H.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*DIM_W-1:0] req_w,
  input  logic [NUM_REQ*DIM_W-1:0] req_h,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef VGA_PLOT_CLIP_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam int XS_W = X_W + EXT;
  localparam int YS_W = Y_W + EXT;

  state_t           r_state;
  state_t           w_state_next;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_win_id;
  logic             w_win_any;
  logic             w_accept;
  logic             w_finish;

  logic [X_W-1:0]   r_x0;
  logic [Y_W-1:0]   r_y0;
  logic [X_W-1:0]   r_vga_x;
  logic [Y_W-1:0]   r_vga_y;
  logic [COL_W-1:0] r_colour;
  logic             r_plot;

  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [DIM_W-1:0] w_sel_w;
  logic [DIM_W-1:0] w_sel_h;
  logic [COL_W-1:0] w_sel_col;
  logic             w_nonempty;

  logic [DIM_W-1:0] w_cx;
  logic [DIM_W-1:0] w_cy;
  logic [DIM_W-1:0] w_cx_nx;
  logic [DIM_W-1:0] w_cy_nx;
  logic             w_active;
  logic             w_row_end;
  logic             w_last;

  logic [XS_W-1:0]  w_xs_acc;
  logic [YS_W-1:0]  w_ys_acc;
  logic [XS_W-1:0]  w_xs_next;
  logic [YS_W-1:0]  w_ys_next;
  logic             w_ok_acc;
  logic             w_ok_next;

  // Scan starting just after the last winner so every client gets a turn.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_win_any = 1'b0;
    w_win_id  = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_any && req_valid[w_idx]) begin
        w_win_any = 1'b1;
        w_win_id  = w_idx;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_win_any;
  assign w_finish = (r_state == S_DRAW) && (w_last || !w_active);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign req_ready[gi] = resetn && w_accept && (w_win_id == ID_W'(gi));
      assign done[gi]      = w_finish && (r_id == ID_W'(gi));
    end
  endgenerate

  assign w_sel_x    = req_x[w_win_id*X_W +: X_W];
  assign w_sel_y    = req_y[w_win_id*Y_W +: Y_W];
  assign w_sel_w    = req_w[w_win_id*DIM_W +: DIM_W];
  assign w_sel_h    = req_h[w_win_id*DIM_W +: DIM_W];
  assign w_sel_col  = req_colour[w_win_id*COL_W +: COL_W];
  assign w_nonempty = (w_sel_w != '0) && (w_sel_h != '0);

  rect_raster #(
    .DIM_W (DIM_W)
  ) u_raster (
    .clock     (clock),
    .resetn    (resetn),
    .i_start   (w_accept),
    .i_w       (w_sel_w),
    .i_h       (w_sel_h),
    .o_cx      (w_cx),
    .o_cy      (w_cy),
    .o_active  (w_active),
    .o_row_end (w_row_end),
    .o_last    (w_last)
  );

  // Output registers are loaded with the pixel the raster will index next cycle.
  assign w_cx_nx   = w_row_end ? '0 : w_cx + 1'b1;
  assign w_cy_nx   = w_row_end ? w_cy + 1'b1 : w_cy;
  assign w_xs_acc  = XS_W'(w_sel_x);
  assign w_ys_acc  = YS_W'(w_sel_y);
  assign w_xs_next = XS_W'(r_x0) + XS_W'(w_cx_nx);
  assign w_ys_next = YS_W'(r_y0) + YS_W'(w_cy_nx);

`ifdef VGA_PLOT_CLIP_EN
  assign w_ok_acc  = (w_xs_acc < XS_W'(SCREEN_W)) && (w_ys_acc < YS_W'(SCREEN_H));
  assign w_ok_next = (w_xs_next < XS_W'(SCREEN_W)) && (w_ys_next < YS_W'(SCREEN_H));
`else
  assign w_ok_acc  = 1'b1;
  assign w_ok_next = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_DRAW;
      S_DRAW:  if (w_finish) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr    <= ID_W'(NUM_REQ - 1);
      r_id     <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else if (w_accept) begin
      r_ptr    <= w_win_id;
      r_id     <= w_win_id;
      r_x0     <= w_sel_x;
      r_y0     <= w_sel_y;
      r_vga_x  <= w_xs_acc[X_W-1:0];
      r_vga_y  <= w_ys_acc[Y_W-1:0];
      r_colour <= w_sel_col;
      r_plot   <= w_nonempty && w_ok_acc;
    end else if ((r_state == S_DRAW) && w_active && !w_last) begin
      r_vga_x  <= w_xs_next[X_W-1:0];
      r_vga_y  <= w_ys_next[Y_W-1:0];
      r_plot   <= w_ok_next;
    end else begin
      r_plot   <= 1'b0;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: arbitration order, raster sequence, empty commands, edge wrap/clip, reset abort.
module tb_vga_plot_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [31:0] req_w;
  logic [31:0] req_h;
  logic [11:0] req_colour;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  vga_plot_arbiter dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int c, input int x, input int y, input int w, input int h, input int col);
    req_x[c*8 +: 8]      = 8'(x);
    req_y[c*7 +: 7]      = 7'(y);
    req_w[c*8 +: 8]      = 8'(w);
    req_h[c*8 +: 8]      = 8'(h);
    req_colour[c*3 +: 3] = 3'(col);
    req_valid[c]         = 1'b1;
  endtask

  // Called with the command presented and granted; walks acceptance, every pixel and the bubble.
  task automatic draw_check(input int id, input int x0, input int y0, input int w, input int h, input int col);
    int n;
    int ex;
    int ey;
    logic ep;
    logic [3:0] edone;
    n = w * h;
    tick;
    req_valid[id] = 1'b0;
    #1;
    chk("ready_in_draw", {28'd0, req_ready}, 32'd0);
    for (int p = 0; p < n; p++) begin
      if (p > 0) tick;
      ex = x0 + (p % w);
      ey = y0 + (p / w);
`ifdef VGA_PLOT_CLIP_EN
      ep = (ex < 160) && (ey < 120);
`else
      ep = 1'b1;
`endif
      edone = (p == n - 1) ? (4'b0001 << id) : 4'b0000;
      chk("pix_plot",   {31'd0, vga_plot}, {31'd0, ep});
      chk("pix_x",      {24'd0, vga_x},    32'(ex % 256));
      chk("pix_y",      {25'd0, vga_y},    32'(ey % 128));
      chk("pix_colour", {29'd0, vga_colour}, 32'(col));
      chk("pix_done",   {28'd0, done},     {28'd0, edone});
      chk("pix_busy",   {31'd0, busy},     32'd1);
    end
    tick;
    chk("bubble_plot", {31'd0, vga_plot}, 32'd0);
    chk("bubble_busy", {31'd0, busy},     32'd0);
    chk("bubble_done", {28'd0, done},     32'd0);
    chk("bubble_hold_x", {24'd0, vga_x},  32'((x0 + w - 1) % 256));
    $display("cmd client=%0d x=%0d y=%0d w=%0d h=%0d pixels=%0d complete", id, x0, y0, w, h, n);
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_colour = '0;

    // Reset state
    #12;
    chk("rst_x",      {24'd0, vga_x},      32'd0);
    chk("rst_y",      {25'd0, vga_y},      32'd0);
    chk("rst_colour", {29'd0, vga_colour}, 32'd0);
    chk("rst_plot",   {31'd0, vga_plot},   32'd0);
    chk("rst_done",   {28'd0, done},       32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_ready",  {28'd0, req_ready},  32'd0);
    tick;
    resetn = 1'b1;
    #1;

    // Client 0: 16x2 at (76,110)
    set_req(0, 76, 110, 16, 2, 7);
    #1;
    chk("t2_ready", {28'd0, req_ready}, 32'b0001);
    draw_check(0, 76, 110, 16, 2, 7);

    // Pointer now at 0: client 1 beats client 0
    set_req(0, 3, 4, 3, 1, 1);
    set_req(1, 8, 9, 2, 2, 3);
    #1;
    chk("rr_1_before_0", {28'd0, req_ready}, 32'b0010);
    draw_check(1, 8, 9, 2, 2, 3);
    chk("rr_then_0", {28'd0, req_ready}, 32'b0001);
    draw_check(0, 3, 4, 3, 1, 1);

    // Clients 0 and 2 together straight from reset
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    set_req(0, 10, 20, 2, 1, 1);
    set_req(2, 40, 50, 2, 1, 4);
    #1;
    chk("t3_first_0", {28'd0, req_ready}, 32'b0001);
    draw_check(0, 10, 20, 2, 1, 1);
    chk("t3_then_2", {28'd0, req_ready}, 32'b0100);
    draw_check(2, 40, 50, 2, 1, 4);

    // Empty command from client 3
    set_req(3, 5, 5, 0, 5, 6);
    #1;
    chk("t4_ready", {28'd0, req_ready}, 32'b1000);
    tick;
    chk("t4_plot_t1", {31'd0, vga_plot}, 32'd0);
    chk("t4_done_t1", {28'd0, done},     32'b1000);
    chk("t4_busy_t1", {31'd0, busy},     32'd1);
    chk("t4_ready_t1", {28'd0, req_ready}, 32'd0);
    tick;
    chk("t4_plot_t2", {31'd0, vga_plot}, 32'd0);
    chk("t4_done_t2", {28'd0, done},     32'd0);
    chk("t4_busy_t2", {31'd0, busy},     32'd0);
    chk("t4_ready_t2", {28'd0, req_ready}, 32'b1000);
    req_valid[3] = 1'b0;
    $display("cmd client=3 w=0 h=5 empty complete");
    #1;

    // Right-edge command: wrap or clip
    set_req(1, 150, 5, 16, 1, 2);
    #1;
    chk("t5_ready", {28'd0, req_ready}, 32'b0010);
    draw_check(1, 150, 5, 16, 1, 2);

    // Reset after the fifth pixel of a 16x2 command
    set_req(2, 30, 40, 16, 2, 5);
    #1;
    chk("t6_ready", {28'd0, req_ready}, 32'b0100);
    tick;
    req_valid[2] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (p > 0) tick;
      chk("t6_pre_plot", {31'd0, vga_plot}, 32'd1);
      chk("t6_pre_x",    {24'd0, vga_x},    32'(30 + p));
    end
    #2;
    resetn = 1'b0;
    req_valid[2] = 1'b1;
    #1;
    chk("t6_abort_plot",  {31'd0, vga_plot}, 32'd0);
    chk("t6_abort_done",  {28'd0, done},     32'd0);
    chk("t6_abort_busy",  {31'd0, busy},     32'd0);
    chk("t6_abort_ready", {28'd0, req_ready}, 32'd0);
    $display("cmd client=2 aborted by reset after 5 pixels");
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("t6_resubmit_ready", {28'd0, req_ready}, 32'b0100);
    draw_check(2, 30, 40, 16, 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
